// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates two writeback sources (ALU on port 0, load unit on port 1)
//   onto a single register-file write port. Round-robin between the two
//   when both are valid, with a pipeline freeze input (hold). The accepted
//   request is presented on the write port one cycle after the transfer.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   hold                  freeze request: no request is accepted while high
//   reqN_valid/reg/data   writeback request from source N (0 = ALU, 1 = load)
//   reqN_ready            combinational accept for source N
//   write_enable/reg/data registered register-file write port
//   last_grant            index of the most recently accepted source
//   conflict_count        saturating count of contended, non-held cycles
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [REG_W-1:0]  req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [REG_W-1:0]  req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              write_enable,
  output logic [REG_W-1:0]  write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              last_grant,
  output logic [7:0]        conflict_count
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic              grant0_p0;
  logic              grant1_p0;
  logic              vld_p0;
  logic              contend_p0;
  logic [REG_W-1:0]  reg_p0;
  logic [DATA_W-1:0] data_p0;

  // Stage p0: combinational arbitration on the live request inputs.
  // Port 0 wins a contention when port 1 was granted last, and vice versa;
  // last_grant resets to 1 so port 0 wins the first contention after reset.
  always_comb begin
    contend_p0 = req0_valid && req1_valid && !hold;
    grant0_p0  = 1'b0;
    grant1_p0  = 1'b0;
    if (!reset && !hold) begin
      grant0_p0 = req0_valid && (!req1_valid || last_grant);
      grant1_p0 = req1_valid && (!req0_valid || !last_grant);
    end
    vld_p0  = grant0_p0 || grant1_p0;
    reg_p0  = grant1_p0 ? req1_reg  : req0_reg;
    data_p0 = grant1_p0 ? req1_data : req0_data;
  end

  assign req0_ready = grant0_p0;
  assign req1_ready = grant1_p0;

  // Stage p1: registered write port and arbitration state.
  // Register 0 is a legal target that is accepted but never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enable   <= 1'b0;
      write_reg      <= '0;
      write_data     <= '0;
      last_grant     <= 1'b1;
      conflict_count <= 8'd0;
    end else begin
      if (vld_p0) begin
        write_enable <= (reg_p0 != '0);
        write_reg    <= reg_p0;
        write_data   <= data_p0;
        last_grant   <= grant1_p0;
      end else begin
        write_enable <= 1'b0;
      end
      if (contend_p0) begin
        conflict_count <= sat_inc8(conflict_count);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed bench for regfile_wb_arbiter. A behavioural model tracks the
//   arbiter's observable state (last winner, pending write, conflict tally)
//   and is compared against the DUT on every falling edge; directed
//   sequences add literal, hand-computed expectations.
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int REG_W  = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              hold = 1'b0;
  logic              v0 = 1'b0, v1 = 1'b0;
  logic [REG_W-1:0]  r0 = '0, r1 = '0;
  logic [DATA_W-1:0] d0 = '0, d1 = '0;
  logic              req0_ready, req1_ready;
  logic              write_enable;
  logic [REG_W-1:0]  write_reg;
  logic [DATA_W-1:0] write_data;
  logic              last_grant;
  logic [7:0]        conflict_count;

  int tests = 0;
  int fails = 0;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req0_valid(v0), .req0_reg(r0), .req0_data(d0), .req0_ready(req0_ready),
    .req1_valid(v1), .req1_reg(r1), .req1_data(d1), .req1_ready(req1_ready),
    .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
    .last_grant(last_grant), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the outputs must currently show.
  logic              m_lg = 1'b1;
  logic              m_we = 1'b0;
  logic [REG_W-1:0]  m_reg = '0;
  logic [DATA_W-1:0] m_data = '0;
  int                m_cc = 0;
  // Model state due at the next rising edge.
  logic              n_lg = 1'b1;
  logic              n_we = 1'b0;
  logic [REG_W-1:0]  n_reg = '0;
  logic [DATA_W-1:0] n_data = '0;
  int                n_cc = 0;

  always @(posedge reset) begin
    m_lg = 1'b1; m_we = 1'b0; m_reg = '0; m_data = '0; m_cc = 0;
  end

  always @(posedge clk) begin
    if (!reset) begin
      m_lg = n_lg; m_we = n_we; m_reg = n_reg; m_data = n_data; m_cc = n_cc;
    end
  end

  // Compare process: inputs are stable from posedge+1, so the falling edge
  // sees the same request set the next rising edge will act on.
  always @(negedge clk) begin
    int winner;
    winner = -1;
    if (!reset && !hold) begin
      if (v0 && v1)  winner = m_lg ? 0 : 1;
      else if (v0)   winner = 0;
      else if (v1)   winner = 1;
    end
    check("ready0", req0_ready, winner == 0);
    check("ready1", req1_ready, winner == 1);
    check("write_enable", write_enable, m_we);
    check("write_reg", write_reg, m_reg);
    check("write_data", write_data, m_data);
    check("last_grant", last_grant, m_lg);
    check("conflict_count", conflict_count, m_cc);

    if (reset) begin
      n_lg = 1'b1; n_we = 1'b0; n_reg = '0; n_data = '0; n_cc = 0;
    end else begin
      n_lg = m_lg; n_reg = m_reg; n_data = m_data; n_we = 1'b0;
      if (winner >= 0) begin
        n_lg   = (winner == 1);
        n_reg  = (winner == 1) ? r1 : r0;
        n_data = (winner == 1) ? d1 : d0;
        n_we   = (n_reg != 0);
      end
      n_cc = m_cc;
      if (v0 && v1 && !hold) n_cc = (m_cc >= 255) ? 255 : m_cc + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [REG_W-1:0]  regs0 [2];
    logic [REG_W-1:0]  regs1 [2];
    logic [DATA_W-1:0] dat0 [2];
    logic [DATA_W-1:0] dat1 [2];
    int order [4];
    int i0, i1, n;

    // Reset state
    repeat (2) tick();
    check("rst write_enable", write_enable, 1'b0);
    check("rst last_grant", last_grant, 1'b1);
    check("rst conflict_count", conflict_count, 8'd0);
    check("rst ready0", req0_ready, 1'b0);
    reset = 1'b0;
    tick();

    // Single ALU write
    v0 = 1'b1; r0 = 6'd5; d0 = 32'hDEADBEEF;
    #2 check("t36 ready0", req0_ready, 1'b1);
    tick();
    v0 = 1'b0;
    check("t36 we", write_enable, 1'b1);
    check("t36 reg", write_reg, 6'd5);
    check("t36 data", write_data, 32'hDEADBEEF);
    tick();
    check("t36 we off", write_enable, 1'b0);
    check("t36 lg", last_grant, 1'b0);

    // Load write to register 0: accepted, no write strobe
    v1 = 1'b1; r1 = 6'd0; d1 = 32'h1234;
    #2 check("t38 ready1", req1_ready, 1'b1);
    tick();
    v1 = 1'b0;
    check("t38 we", write_enable, 1'b0);
    check("t38 lg", last_grant, 1'b1);

    // Contention: alternate grants
    regs0[0] = 6'd1; regs0[1] = 6'd3; dat0[0] = 32'hA1; dat0[1] = 32'hA3;
    regs1[0] = 6'd2; regs1[1] = 6'd4; dat1[0] = 32'hB2; dat1[1] = 32'hB4;
    i0 = 0; i1 = 0; n = 0;
    for (int c = 0; c < 8 && (i0 < 2 || i1 < 2); c++) begin
      v0 = (i0 < 2); v1 = (i1 < 2);
      if (i0 < 2) begin r0 = regs0[i0]; d0 = dat0[i0]; end
      if (i1 < 2) begin r1 = regs1[i1]; d1 = dat1[i1]; end
      #2;
      if (req0_ready && n < 4) begin order[n] = 0; n++; i0++; end
      else if (req1_ready && n < 4) begin order[n] = 1; n++; i1++; end
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;
    check("t37 transfers", n, 4);
    check("t37 g0", order[0], 0);
    check("t37 g1", order[1], 1);
    check("t37 g2", order[2], 0);
    check("t37 g3", order[3], 1);
    check("t37 last reg", write_reg, 6'd4);
    check("t37 cc", conflict_count, 8'd3);

    // Hold freezes both ports
    v0 = 1'b1; r0 = 6'd7; d0 = 32'h77;
    v1 = 1'b1; r1 = 6'd8; d1 = 32'h88;
    hold = 1'b1;
    repeat (3) begin
      #2;
      check("t39 held ready0", req0_ready, 1'b0);
      check("t39 held ready1", req1_ready, 1'b0);
      tick();
      check("t39 held we", write_enable, 1'b0);
    end
    check("t39 cc held", conflict_count, 8'd3);
    hold = 1'b0;
    #2 check("t39 release ready0", req0_ready, 1'b1);
    tick();
    v0 = 1'b0;
    check("t39 w reg7", write_reg, 6'd7);
    #2 check("t39 ready1", req1_ready, 1'b1);
    tick();
    v1 = 1'b0;
    check("t39 w reg8", write_reg, 6'd8);
    check("t39 w data", write_data, 32'h88);
    check("t39 lg", last_grant, 1'b1);
    check("t39 cc", conflict_count, 8'd4);

    // Long contention saturates the counter
    v0 = 1'b1; r0 = 6'd9;  d0 = 32'h99;
    v1 = 1'b1; r1 = 6'd10; d1 = 32'hAA;
    repeat (300) tick();
    check("t40 cc sat", conflict_count, 8'd255);
    repeat (5) tick();
    check("t40 cc stays", conflict_count, 8'd255);

    // Asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    check("t41 we", write_enable, 1'b0);
    check("t41 reg", write_reg, 6'd0);
    check("t41 data", write_data, 32'h0);
    check("t41 cc", conflict_count, 8'd0);
    check("t41 lg", last_grant, 1'b1);
    check("t41 ready0", req0_ready, 1'b0);
    check("t41 ready1", req1_ready, 1'b0);
    tick();
    tick();
    check("t41 no write", write_enable, 1'b0);
    reset = 1'b0;
    #2 check("t41 first ready0", req0_ready, 1'b1);
    tick();
    check("t41 lg0", last_grant, 1'b0);
    check("t41 reg9", write_reg, 6'd9);
    check("t41 we", write_enable, 1'b1);
    v0 = 1'b0; v1 = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the write-data width.
REQ-002 Parameter REG_W, default 6, SHALL set the register-number width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 hold  input  1  SHALL be the writeback freeze request from the pipeline controller.
REQ-006 req0_valid  input  1  SHALL flag an ALU writeback request.
REQ-007 req0_reg  input  REG_W  SHALL give the ALU destination register number.
REQ-008 req0_data  input  DATA_W  SHALL give the ALU result.
REQ-009 req0_ready  output  1  SHALL signal that the ALU request is accepted this cycle.
REQ-010 req1_valid, req1_reg, req1_data, req1_ready SHALL be the same as REQ-006..009, for the load-unit writeback.
REQ-011 write_enable  output  1  SHALL drive the register-file write enable.
REQ-012 write_reg  output  REG_W  SHALL drive the register-file destination number.
REQ-013 write_data  output  DATA_W  SHALL drive the register-file write data.
REQ-014 last_grant  output  1  SHALL show the requester (0/1) accepted most recently.
REQ-015 conflict_count  output  8  SHALL count cycles in which both requests were valid and hold was 0.

Function
REQ-016 A transfer on port n SHALL occur in a cycle where reqn_valid=1 and reqn_ready=1.
REQ-017 reqn_ready SHALL be combinational, may depend on both valid inputs, on hold and on last_grant, and SHALL be 0 whenever reqn_valid=0.
REQ-018 At most one ready SHALL be asserted per cycle.
REQ-019 hold=1 SHALL force both readies to 0.
REQ-020 With hold=0 and exactly one valid, that port SHALL be ready.
REQ-021 With hold=0 and both valid, the port that is not last_grant SHALL be ready (round-robin).
REQ-022 On every transfer, last_grant SHALL update on the next edge to the accepted port's index; otherwise last_grant SHALL hold.
REQ-023 The outputs write_enable, write_reg and write_data SHALL be registered, with exactly one cycle of latency from the transfer edge.
REQ-024 After a transfer, write_reg and write_data SHALL take the accepted port's reg and data.
REQ-025 write_enable SHALL be 1 the cycle after a transfer whose reg is nonzero, and 0 otherwise.
REQ-026 A transfer with reg=0 SHALL be accepted and SHALL update last_grant, but SHALL NOT assert write_enable.
REQ-027 In cycles with no transfer, write_enable SHALL be 0, and write_reg and write_data SHALL hold their last values.
REQ-028 Requests carrying the same register number on both ports SHALL be written in grant order; the later grant's data SHALL be the final value.
REQ-029 conflict_count SHALL increment by 1 per qualifying cycle and SHALL saturate at 255.
REQ-030 A requester SHALL hold valid, reg and data stable until accepted; the block SHALL NOT buffer a rejected request.
REQ-031 If hold rises while a request is waiting, the request SHALL remain pending with no loss; the registered write of the previous cycle's transfer SHALL still be presented.

Reset
REQ-032 Assertion of reset SHALL immediately clear write_enable, write_reg, write_data and conflict_count to 0, and set last_grant to 1, independent of clk.
REQ-033 While reset=1, both readies SHALL be 0.
REQ-034 A transfer coinciding with a reset edge SHALL be discarded, and no write SHALL appear afterward.
REQ-035 After reset release, the first contended cycle SHALL grant port 0.

Verification
REQ-036 Reset, then req0 valid with reg=5, data=0xDEADBEEF for one cycle -> req0_ready=1 that cycle; next cycle write_enable=1, write_reg=5, write_data=0xDEADBEEF; the following cycle write_enable=0.
REQ-037 Both ports valid for 4 cycles (reg 1..4, distinct data), each port holding until accepted -> grants alternate 0,1,0,1; writes appear 1 cycle later in that order; conflict_count=3 (last cycle only one pending).
REQ-038 req1 valid with reg=0, data=0x1234 -> req1_ready=1; next cycle write_enable=0; last_grant=1.
REQ-039 Both ports valid with hold=1 for 3 cycles, then hold=0 -> no readies and write_enable=0 while held; conflict_count unchanged; the grant after release goes to the port opposite last_grant.
REQ-040 Both ports valid continuously for 300 cycles -> conflict_count=255 and stays 255.
REQ-041 Assert reset asynchronously mid-stream (between edges) -> outputs clear immediately per REQ-032; after release, port 0 wins the first contention.
